uart_rx_controller: RTL and testbench

//  Sequences the RX baud generator: detects the start bit, loads half-bit then full-bit divisors,

---
 rtl/uart_rx_controller.sv | 215 +++++++++++++++++++++
 tb/tb_uart_rx_controller.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_controller.sv
// UART receive sequencer: drives an external baud generator, samples RXD mid-bit and
// presents each byte on a valid/ready port. Optional parity via `UART_RX_PARITY_EN.
module uart_rx_controller #(
  parameter  int CLKS_PER_BIT = 434,
  parameter  int DATA_BITS    = 8,
  localparam int DW           = $clog2(CLKS_PER_BIT) + 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 RXD,
  output logic                 BG_CE,
  output logic                 BG_SPE,
  output logic [DW-1:0]        BG_D,
  input  logic                 BG_ZD,
  output logic [DATA_BITS-1:0] RX_DATA,
  output logic                 RX_VALID,
  input  logic                 RX_READY,
  output logic                 FRAME_ERR,
  output logic                 OVERRUN,
  output logic                 PAR_ERR
);

  localparam int             IW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IW-1:0]  LAST_IDX = IW'(DATA_BITS - 1);
  localparam logic [DW-1:0]  HALF_D   = DW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [DW-1:0]  FULL_D   = DW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
`ifdef UART_RX_PARITY_EN
    S_BREAK  = 3'd4,
    S_PARITY = 3'd5
`else
    S_BREAK  = 3'd4
`endif
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 r_rx_meta;
  logic                 r_rxs;
  logic                 r_rxs_d;
  logic [IW-1:0]        r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_frame_err;
  logic                 r_overrun;
  logic                 w_fall;
  logic                 w_ce;
  logic                 w_spe;
  logic [DW-1:0]        w_d;
  logic                 w_stop_tick;
  logic                 w_par_bad;
  logic                 w_accept;
  logic                 w_hs;

  // Synchroniser flops idle high so reset never looks like a start edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
      r_rxs_d   <= 1'b1;
    end else begin
      r_rx_meta <= RXD;
      r_rxs     <= r_rx_meta;
      r_rxs_d   <= r_rxs;
    end
  end

  assign w_fall = r_rxs_d & ~r_rxs;

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_ce        = 1'b0;
    w_spe       = 1'b0;
    w_d         = '0;
    w_stop_tick = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_ce   = 1'b1;
          w_spe  = 1'b1;
          w_d    = HALF_D;
          w_next = S_START;
        end
      end
      S_START: begin
        w_ce = 1'b1;
        if (BG_ZD) begin
          if (r_rxs) begin
            w_ce   = 1'b0;
            w_next = S_IDLE;
          end else begin
            w_spe  = 1'b1;
            w_d    = FULL_D;
            w_next = S_DATA;
          end
        end
      end
      S_DATA: begin
        w_ce = 1'b1;
        if (BG_ZD) begin
          w_spe = 1'b1;
          w_d   = FULL_D;
          if (r_idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
            w_next = S_PARITY;
`else
            w_next = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        w_ce = 1'b1;
        if (BG_ZD) begin
          w_spe  = 1'b1;
          w_d    = FULL_D;
          w_next = S_STOP;
        end
      end
`endif
      S_STOP: begin
        w_ce = 1'b1;
        if (BG_ZD) begin
          w_ce        = 1'b0;
          w_stop_tick = 1'b1;
          w_next      = r_rxs ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: begin
        if (r_rxs) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Generator controls are combinational; forced quiet while reset is held.
  assign BG_CE  = w_ce & ~RST;
  assign BG_SPE = w_spe & ~RST;
  assign BG_D   = RST ? '0 : w_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_idx   <= '0;
      r_shift <= '0;
    end else if (r_state == S_START && BG_ZD) begin
      r_idx <= '0;
    end else if (r_state == S_DATA && BG_ZD) begin
      r_shift[r_idx] <= r_rxs;
      r_idx          <= r_idx + IW'(1);
    end
  end

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = 1'b0;
  logic r_par_bit;
  logic r_par_err;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_par_bit <= 1'b0;
      r_par_err <= 1'b0;
    end else begin
      if (r_state == S_PARITY && BG_ZD) r_par_bit <= r_rxs;
      r_par_err <= w_stop_tick & w_par_bad;
    end
  end

  assign w_par_bad = ((^r_shift) ^ PAR_ODD) != r_par_bit;
  assign PAR_ERR   = r_par_err;
`else
  assign w_par_bad = 1'b0;
  assign PAR_ERR   = 1'b0;
`endif

  assign w_accept = w_stop_tick & r_rxs & ~w_par_bad;
  assign w_hs     = r_rx_valid & RX_READY;

  // A handshake in the completion cycle frees the slot, so the new byte loads cleanly.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_stop_tick & ~r_rxs;
      if (w_accept && (!r_rx_valid || w_hs)) begin
        r_rx_data  <= r_shift;
        r_rx_valid <= 1'b1;
      end else if (w_hs) begin
        r_rx_valid <= 1'b0;
      end
      if (w_hs)                        r_overrun <= 1'b0;
      else if (w_accept && r_rx_valid) r_overrun <= 1'b1;
    end
  end

  assign RX_DATA   = r_rx_data;
  assign RX_VALID  = r_rx_valid;
  assign FRAME_ERR = r_frame_err;
  assign OVERRUN   = r_overrun;

endmodule

// File: tb/tb_uart_rx_controller.sv
// Bench for uart_rx_controller: behavioural baud generator, serial driver tasks and a
// scoreboard of expected bytes checked at each RX handshake.
module tb_uart_rx_controller;

  localparam int CPB = 16;
  localparam int DB  = 8;
  localparam int DW  = $clog2(CPB) + 1;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          rxd;
  logic          rx_ready;
  logic          bg_zd;
  logic          bg_ce;
  logic          bg_spe;
  logic [DW-1:0] bg_d;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          overrun;
  logic          par_err;

  int checks = 0;
  int failures = 0;
  logic [DB-1:0] exp_q[$];
  logic [DW-1:0] spe_log[$];
  int n_valid_cyc = 0;
  int n_ferr_cyc = 0;
  int n_perr_cyc = 0;
  int n_spe = 0;
  logic prev_spe = 1'b0;
  logic [DW-1:0] bg_cnt;

  // clock / reset block
  always #5 clk = ~clk;

  uart_rx_controller #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) u_dut (
    .CLK      (clk),
    .RST      (rst),
    .RXD      (rxd),
    .BG_CE    (bg_ce),
    .BG_SPE   (bg_spe),
    .BG_D     (bg_d),
    .BG_ZD    (bg_zd),
    .RX_DATA  (rx_data),
    .RX_VALID (rx_valid),
    .RX_READY (rx_ready),
    .FRAME_ERR(frame_err),
    .OVERRUN  (overrun),
    .PAR_ERR  (par_err)
  );

  // Baud generator model: load on SPE, count down while enabled, tick on reaching zero.
  always @(posedge clk) begin
    if (rst) begin
      bg_cnt <= '0;
      bg_zd  <= 1'b0;
    end else begin
      bg_zd <= 1'b0;
      if (bg_spe) bg_cnt <= bg_d;
      else if (bg_ce && bg_cnt != 0) begin
        bg_cnt <= bg_cnt - 1'b1;
        if (bg_cnt == 1) bg_zd <= 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard / monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (bg_spe) begin
        check("spe_single", {31'b0, prev_spe}, 32'd0);
        spe_log.push_back(bg_d);
        n_spe++;
      end
      prev_spe = bg_spe;
      if (rx_valid)  n_valid_cyc++;
      if (frame_err) n_ferr_cyc++;
      if (par_err)   n_perr_cyc++;
      if (rx_valid && rx_ready) begin
        check("sb_pending", {31'b0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) check("rx_data", {24'b0, rx_data}, {24'b0, exp_q.pop_front()});
      end
    end else begin
      prev_spe = 1'b0;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b, input int n);
    rxd = b;
    repeat (n) tick();
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input bit stop_low, input bit bad_par,
                            input bit push);
    if (push) exp_q.push_back(d);
    drive_bit(1'b0, CPB);
    for (int i = 0; i < DB; i++) drive_bit(d[i], CPB);
    if (PAR_EN) drive_bit((^d) ^ bad_par, CPB);
    if (stop_low) drive_bit(1'b0, 40);
    drive_bit(1'b1, CPB);
    drive_bit(1'b1, 4);
  endtask

  task automatic wait_drain(input string tag);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      tick();
      k++;
    end
    check(tag, exp_q.size(), 32'd0);
    repeat (4) tick();
  endtask

  initial begin
    int v0;
    int f0;
    int s0;
    int nbad;
    rst      = 1'b1;
    rxd      = 1'b1;
    rx_ready = 1'b1;
    repeat (3) tick();
    check("rst_bg_ce",     {31'b0, bg_ce}, 32'd0);
    check("rst_bg_spe",    {31'b0, bg_spe}, 32'd0);
    check("rst_bg_d",      {27'b0, bg_d}, 32'd0);
    check("rst_rx_valid",  {31'b0, rx_valid}, 32'd0);
    check("rst_rx_data",   {24'b0, rx_data}, 32'd0);
    check("rst_frame_err", {31'b0, frame_err}, 32'd0);
    check("rst_overrun",   {31'b0, overrun}, 32'd0);
    check("rst_par_err",   {31'b0, par_err}, 32'd0);
    rst = 1'b0;
    repeat (4) tick();

    // 1: clean 0xA5 with consumer ready
    spe_log.delete();
    v0 = n_valid_cyc;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    wait_drain("t1_drain");
    check("t1_spe_count", spe_log.size(), 32'd10);
    check("t1_spe_first", {27'b0, spe_log[0]}, 32'd7);
    nbad = 0;
    for (int i = 1; i < spe_log.size(); i++) if (spe_log[i] != 5'd15) nbad++;
    check("t1_spe_reload", nbad, 32'd0);
    check("t1_valid_cycles", n_valid_cyc - v0, 32'd1);

    // 2: short glitch is a false start
    s0 = n_spe;
    v0 = n_valid_cyc;
    f0 = n_ferr_cyc;
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 30);
    check("t2_bg_ce", {31'b0, bg_ce}, 32'd0);
    check("t2_spe_count", n_spe - s0, 32'd1);
    check("t2_valid", n_valid_cyc - v0, 32'd0);
    check("t2_ferr", n_ferr_cyc - f0, 32'd0);

    // 3: stop held low, then recovery
    v0 = n_valid_cyc;
    f0 = n_ferr_cyc;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    check("t3_ferr_pulse", n_ferr_cyc - f0, 32'd1);
    check("t3_no_valid", n_valid_cyc - v0, 32'd0);
    send_frame(8'h55, 1'b0, 1'b0, 1'b1);
    wait_drain("t3_drain");
    check("t3_ferr_after", n_ferr_cyc - f0, 32'd1);

    // 4: overrun while consumer stalled
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    check("t4_valid_first", {31'b0, rx_valid}, 32'd1);
    check("t4_ovr_first", {31'b0, overrun}, 32'd0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0);
    check("t4_valid_held", {31'b0, rx_valid}, 32'd1);
    check("t4_data_held", {24'b0, rx_data}, 32'h11);
    check("t4_overrun", {31'b0, overrun}, 32'd1);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    check("t4_valid_clr", {31'b0, rx_valid}, 32'd0);
    check("t4_ovr_clr", {31'b0, overrun}, 32'd0);
    check("t4_sb_empty", exp_q.size(), 32'd0);
    rx_ready = 1'b1;
    repeat (4) tick();

    // 5: reset mid-frame
    v0 = n_valid_cyc;
    f0 = n_ferr_cyc;
    drive_bit(1'b0, CPB);
    drive_bit(1'b1, 4 * CPB + 8);
    rst = 1'b1;
    repeat (2) tick();
    check("t5_rst_outputs", {13'b0, bg_ce, bg_spe, bg_d, rx_valid, frame_err, overrun, par_err,
                             rx_data}, 32'd0);
    tick();
    rst = 1'b0;
    repeat (4) tick();
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    wait_drain("t5_drain");
    check("t5_valid_cycles", n_valid_cyc - v0, 32'd1);
    check("t5_no_ferr", n_ferr_cyc - f0, 32'd0);
    check("t5_no_ovr", {31'b0, overrun}, 32'd0);

`ifdef UART_RX_PARITY_EN
    // 6: parity good then bad
    send_frame(8'h07, 1'b0, 1'b0, 1'b1);
    wait_drain("t6_drain");
    v0 = n_valid_cyc;
    send_frame(8'h07, 1'b0, 1'b1, 1'b0);
    repeat (4) tick();
    check("t6_par_pulse", n_perr_cyc, 32'd1);
    check("t6_no_valid", n_valid_cyc - v0, 32'd0);
`else
    check("par_err_never", n_perr_cyc, 32'd0);
`endif

    check("sb_final_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
